sc_auxcounter_scheduler: RTL

Sequencer for the game's auxiliary up-counter: on a start request it clears the counter, then paces its active-low upcount input at a programmable prescaled rate until the counter reaches a programmed limit, then signals done. It sits between the game FSM (start/pause/config) and the auxiliary counter, closing the loop through the counter's data bus, and is the only driver of that counter's upcount and clear inputs.

---
 rtl/sc_auxcounter_pkg.sv | 29 ++
 rtl/sc_aux_prescaler.sv | 38 +++
 rtl/sc_auxcounter_scheduler.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/sc_auxcounter_pkg.sv
// Shared state encoding, default widths and state helpers for the aux-counter scheduler.
package sc_auxcounter_pkg;

    localparam int AUX_DATAWIDTH_DEFAULT  = 8;
    localparam int PRESCALE_WIDTH_DEFAULT = 20;

    localparam int STATE_WIDTH = 3;

    localparam logic [2:0] STATE_IDLE  = 3'd0;
    localparam logic [2:0] STATE_CLEAR = 3'd1;
    localparam logic [2:0] STATE_RUN   = 3'd2;
    localparam logic [2:0] STATE_PAUSE = 3'd3;
    localparam logic [2:0] STATE_DONE  = 3'd4;

    function automatic logic isBusyState(input logic [2:0] stateValue);
        return (stateValue == STATE_CLEAR) ||
               (stateValue == STATE_RUN)   ||
               (stateValue == STATE_PAUSE);
    endfunction

    function automatic logic isKnownState(input logic [2:0] stateValue);
        return (stateValue == STATE_IDLE)  ||
               (stateValue == STATE_CLEAR) ||
               (stateValue == STATE_RUN)   ||
               (stateValue == STATE_PAUSE) ||
               (stateValue == STATE_DONE);
    endfunction

endpackage

// File: rtl/sc_aux_prescaler.sv
// Tick-period counter: counts 0..period, wraps on match; clear beats hold beats enable.
module sc_aux_prescaler
    import sc_auxcounter_pkg::*;
#(
    parameter int PRESCALE_WIDTH = PRESCALE_WIDTH_DEFAULT
)(
    input  logic                      SC_auxCOUNTER_CLOCK_50,
    input  logic                      SC_auxCOUNTER_RESET_InHigh,
    input  logic                      clear,
    input  logic                      hold,
    input  logic                      enable,
    input  logic [PRESCALE_WIDTH-1:0] period,
    output logic                      match
);

    localparam logic [PRESCALE_WIDTH-1:0] PRESCALE_ONE = PRESCALE_WIDTH'(1);

    logic [PRESCALE_WIDTH-1:0] periodCount;

    assign match = (periodCount == period);

    always_ff @(posedge SC_auxCOUNTER_CLOCK_50 or posedge SC_auxCOUNTER_RESET_InHigh) begin
        if (SC_auxCOUNTER_RESET_InHigh) begin
            periodCount <= '0;
        end else if (clear) begin
            periodCount <= '0;
        end else if (hold) begin
            periodCount <= periodCount;
        end else if (enable) begin
            if (match) begin
                periodCount <= '0;
            end else begin
                periodCount <= periodCount + PRESCALE_ONE;
            end
        end
    end

endmodule

// File: rtl/sc_auxcounter_scheduler.sv
// Sequences the auxiliary up-counter: clear, paced upcount ticks up to a limit, then a done pulse.
//
// state | meaning
// IDLE  | waiting for start request, counter untouched
// CLEAR | one cycle, counter cleared, prescaler zeroed
// RUN   | pacing upcount ticks until effective count reaches limit
// PAUSE | prescaler frozen, no ticks issued
// DONE  | one cycle, done pulse, then back to IDLE
module sc_auxcounter_scheduler
    import sc_auxcounter_pkg::*;
#(
    parameter int auxCOUNTER_DATAWIDTH = AUX_DATAWIDTH_DEFAULT,
    parameter int PRESCALE_WIDTH       = PRESCALE_WIDTH_DEFAULT
)(
    input  logic                            SC_auxCOUNTER_CLOCK_50,
    input  logic                            SC_auxCOUNTER_RESET_InHigh,
    input  logic                            start_InLow,
    input  logic                            pause_InLow,
    input  logic [PRESCALE_WIDTH-1:0]       prescale_InBUS,
    input  logic [auxCOUNTER_DATAWIDTH-1:0] limit_InBUS,
    input  logic [auxCOUNTER_DATAWIDTH-1:0] count_InBUS,
    output logic                            upcount_OutLow,
    output logic                            clear_OutHigh,
    output logic                            busy_OutHigh,
    output logic                            done_OutHigh
);

    logic [STATE_WIDTH-1:0]          stateReg;
    logic [STATE_WIDTH-1:0]          stateNext;
    logic [PRESCALE_WIDTH-1:0]       periodReg;
    logic [auxCOUNTER_DATAWIDTH-1:0] limitReg;

    logic                            upcountNext;
    logic                            clearNext;
    logic                            doneNext;
    logic                            busyNext;
    logic                            captureParams;

    logic                            prescaleClear;
    logic                            prescaleHold;
    logic                            prescaleEnable;
    logic                            prescaleMatch;

    logic [auxCOUNTER_DATAWIDTH:0]   effectiveCount;
    logic                            terminalHit;
    logic                            startRequest;

    // An issued-but-not-yet-visible increment is counted here so the last tick never overshoots.
    assign effectiveCount = {1'b0, count_InBUS} +
                            {{auxCOUNTER_DATAWIDTH{1'b0}}, ~upcount_OutLow};
    assign terminalHit    = (effectiveCount == {1'b0, limitReg});
    assign startRequest   = ~start_InLow;

    sc_aux_prescaler #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_prescaler (
        .SC_auxCOUNTER_CLOCK_50     (SC_auxCOUNTER_CLOCK_50),
        .SC_auxCOUNTER_RESET_InHigh (SC_auxCOUNTER_RESET_InHigh),
        .clear                      (prescaleClear),
        .hold                       (prescaleHold),
        .enable                     (prescaleEnable),
        .period                     (periodReg),
        .match                      (prescaleMatch)
    );

    always_comb begin
        stateNext      = stateReg;
        upcountNext    = 1'b1;
        clearNext      = 1'b0;
        doneNext       = 1'b0;
        captureParams  = 1'b0;
        prescaleClear  = 1'b0;
        prescaleHold   = 1'b0;
        prescaleEnable = 1'b0;

        case (stateReg)
            STATE_IDLE: begin
                if (startRequest) begin
                    stateNext     = STATE_CLEAR;
                    captureParams = 1'b1;
                    clearNext     = 1'b1;
                end
            end

            STATE_CLEAR: begin
                prescaleClear = 1'b1;
                stateNext     = STATE_RUN;
            end

            STATE_RUN: begin
                if (startRequest) begin
                    stateNext     = STATE_CLEAR;
                    captureParams = 1'b1;
                    clearNext     = 1'b1;
                end else if (terminalHit) begin
                    stateNext = STATE_DONE;
                    doneNext  = 1'b1;
                end else if (!pause_InLow) begin
                    stateNext    = STATE_PAUSE;
                    prescaleHold = 1'b1;
                end else begin
                    prescaleEnable = 1'b1;
                    upcountNext    = ~prescaleMatch;
                end
            end

            STATE_PAUSE: begin
                if (startRequest) begin
                    stateNext     = STATE_CLEAR;
                    captureParams = 1'b1;
                    clearNext     = 1'b1;
                end else if (pause_InLow) begin
                    // Resume cycle already advances pacing, so a pause costs exactly its length.
                    stateNext      = STATE_RUN;
                    prescaleEnable = 1'b1;
                    upcountNext    = ~prescaleMatch;
                end else begin
                    prescaleHold = 1'b1;
                end
            end

            STATE_DONE: begin
                if (startRequest) begin
                    stateNext     = STATE_CLEAR;
                    captureParams = 1'b1;
                    clearNext     = 1'b1;
                end else begin
                    stateNext = STATE_IDLE;
                end
            end

            default: begin
                stateNext = STATE_IDLE;
            end
        endcase

        busyNext = isBusyState(stateNext);
    end

    always_ff @(posedge SC_auxCOUNTER_CLOCK_50 or posedge SC_auxCOUNTER_RESET_InHigh) begin
        if (SC_auxCOUNTER_RESET_InHigh) begin
            stateReg       <= STATE_IDLE;
            upcount_OutLow <= 1'b1;
            clear_OutHigh  <= 1'b0;
            busy_OutHigh   <= 1'b0;
            done_OutHigh   <= 1'b0;
            periodReg      <= '0;
            limitReg       <= '0;
        end else begin
            stateReg       <= isKnownState(stateNext) ? stateNext : STATE_IDLE;
            upcount_OutLow <= upcountNext;
            clear_OutHigh  <= clearNext;
            busy_OutHigh   <= busyNext;
            done_OutHigh   <= doneNext;
            if (captureParams) begin
                periodReg <= prescale_InBUS;
                limitReg  <= limit_InBUS;
            end
        end
    end

endmodule
